// File: rtl/uart_frame_sender.sv
// uart_frame_sender: frames one DATA_W-bit word into a byte stream for a
// byte-wide UART transmitter. The frame is a sync byte, then the data bytes
// MSB-first, then an optional XOR checksum byte. A start/busy handshake paces
// each byte, and a watchdog aborts the frame if the transmitter never responds.
module uart_frame_sender #(
   parameter int         DATA_W      = 32,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter bit         CHK_EN      = 1'b1,
   parameter int         ACK_TIMEOUT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              tx_start,
   output logic [7:0]        tx_byte,
   input  logic              tx_busy,
   output logic              frame_busy,
   output logic              frame_done,
   output logic              frame_err
);

   localparam int NB        = DATA_W / 8;
   localparam int FRAME_LEN = 1 + NB + (CHK_EN ? 1 : 0);
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);
   localparam int TMO_W     = $clog2(ACK_TIMEOUT + 1);

   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 1);
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(ACK_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_HI,
      WAIT_LO,
      DONE
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  byte_cnt, byte_cnt_nx;
   logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nx;
   logic [DATA_W-1:0] word_q, word_nx;
   logic [7:0]        chk_q, chk_nx;
   logic [7:0]        tx_byte_nx;
   logic [7:0]        cur_byte;
   logic              tx_start_nx;
   logic              frame_busy_nx;
   logic              frame_done_nx;
   logic              frame_err_nx;

   // XOR of all data bytes; the sync byte is deliberately not part of it
   function automatic logic [7:0] xor_bytes(input logic [DATA_W-1:0] w);
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < NB; i++) begin
         acc = acc ^ w[8*i +: 8];
      end
      return acc;
   endfunction

   // Only combinational output: a word is accepted whenever the FSM sits idle
   assign in_ready = (state == IDLE) && !rst;

   // Picks the frame byte addressed by byte_cnt (sync, data MSB-first, checksum)
   always_comb begin
      cur_byte = SYNC_BYTE;
      for (int i = 1; i <= NB; i++) begin
         if (byte_cnt == CNT_W'(i)) begin
            cur_byte = word_q[DATA_W-8*i +: 8];
         end
      end
      if (CHK_EN && (byte_cnt == CNT_W'(NB + 1))) begin
         cur_byte = chk_q;
      end
   end

   // Next-state and next-output logic for the frame sequencer
   always_comb begin
      state_nx      = state;
      byte_cnt_nx   = byte_cnt;
      tmo_cnt_nx    = tmo_cnt;
      word_nx       = word_q;
      chk_nx        = chk_q;
      tx_byte_nx    = tx_byte;
      tx_start_nx   = 1'b0;
      frame_busy_nx = frame_busy;
      frame_done_nx = 1'b0;
      frame_err_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               word_nx       = in_data;
               chk_nx        = CHK_EN ? xor_bytes(in_data) : 8'h00;
               byte_cnt_nx   = '0;
               frame_busy_nx = 1'b1;
               state_nx      = ISSUE;
            end
         end
         ISSUE: begin
            if (!tx_busy) begin
               tx_byte_nx  = cur_byte;
               tx_start_nx = 1'b1;
               tmo_cnt_nx  = '0;
               state_nx    = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (tx_busy) begin
               state_nx = WAIT_LO;
            end else begin
               tmo_cnt_nx = tmo_cnt + TMO_W'(1);
               if (tmo_cnt_nx == TMO_LIMIT) begin
                  frame_err_nx  = 1'b1;
                  frame_busy_nx = 1'b0;
                  state_nx      = IDLE;
               end
            end
         end
         WAIT_LO: begin
            if (!tx_busy) begin
               if (byte_cnt == LAST_CNT) begin
                  state_nx = DONE;
               end else begin
                  byte_cnt_nx = byte_cnt + CNT_W'(1);
                  state_nx    = ISSUE;
               end
            end
         end
         DONE: begin
            frame_done_nx = 1'b1;
            frame_busy_nx = 1'b0;
            state_nx      = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any frame immediately
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         byte_cnt   <= '0;
         tmo_cnt    <= '0;
         word_q     <= '0;
         chk_q      <= '0;
         tx_byte    <= '0;
         tx_start   <= 1'b0;
         frame_busy <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nx;
         byte_cnt   <= byte_cnt_nx;
         tmo_cnt    <= tmo_cnt_nx;
         word_q     <= word_nx;
         chk_q      <= chk_nx;
         tx_byte    <= tx_byte_nx;
         tx_start   <= tx_start_nx;
         frame_busy <= frame_busy_nx;
         frame_done <= frame_done_nx;
         frame_err  <= frame_err_nx;
      end
   end

endmodule
